// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage CPU.
// Covers load-use stalls, EX-stage redirects, multi-cycle stack ops and
// memory-busy freezes. It also keeps saturating stall and flush counters.
module pipe_hazard_ctrl #(
   parameter int REG_W     = 5,
   parameter int STACK_LAT = 2,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_dest_reg,
   input  logic             ex_branch_taken,
   input  logic             ex_call,
   input  logic             ex_ret,
   input  logic             ex_pop,
   input  logic             mem_busy,
   input  logic             clear_counts,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_stall,
   output logic             idex_bubble,
   output logic             exmem_stall,
   output logic             exmem_bubble,
   output logic             redirect,
   output logic             busy_state,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int SCNT_W = $clog2(STACK_LAT + 1);
   // Number of extra STACK cycles after the entry cycle. A latency of 1 never enters STACK.
   localparam logic [SCNT_W-1:0] SCNT_INIT = (STACK_LAT >= 2) ? SCNT_W'(STACK_LAT - 2) : '0;

   typedef enum logic {RUN = 1'b0, STACK = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [SCNT_W-1:0] scnt_q, scnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic hz, stack_op, redir_op;
   logic c_pc_stall, c_ifid_stall, c_ifid_flush, c_idex_stall;
   logic c_idex_bubble, c_exmem_stall, c_exmem_bubble, c_redirect;

   // Register 0 is hardwired, so it can never cause a load-use hazard.
   assign hz = ex_mem_read && (ex_dest_reg != '0) &&
               ((id_rs_used && (id_rs == ex_dest_reg)) ||
                (id_rt_used && (id_rt == ex_dest_reg)));
   assign stack_op = ex_call | ex_ret | ex_pop;
   assign redir_op = ex_call | ex_ret;

   // Next-state and control decode. Priority: mem_busy, then stack op, then branch, then hazard.
   always_comb begin
      state_d        = state_q;
      scnt_d         = scnt_q;
      c_pc_stall     = 1'b0;
      c_ifid_stall   = 1'b0;
      c_ifid_flush   = 1'b0;
      c_idex_stall   = 1'b0;
      c_idex_bubble  = 1'b0;
      c_exmem_stall  = 1'b0;
      c_exmem_bubble = 1'b0;
      c_redirect     = 1'b0;
      if (mem_busy) begin
         c_pc_stall    = 1'b1;
         c_ifid_stall  = 1'b1;
         c_idex_stall  = 1'b1;
         c_exmem_stall = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (stack_op) begin
                  if (STACK_LAT == 1) begin
                     // A single-cycle stack op releases immediately.
                     c_redirect    = redir_op;
                     c_ifid_flush  = redir_op;
                     c_idex_bubble = redir_op;
                  end else begin
                     c_pc_stall     = 1'b1;
                     c_ifid_stall   = 1'b1;
                     c_idex_stall   = 1'b1;
                     c_exmem_bubble = 1'b1;
                     scnt_d         = SCNT_INIT;
                     state_d        = STACK;
                  end
               end else if (ex_branch_taken) begin
                  c_redirect    = 1'b1;
                  c_ifid_flush  = 1'b1;
                  c_idex_bubble = 1'b1;
               end else if (hz) begin
                  c_pc_stall    = 1'b1;
                  c_ifid_stall  = 1'b1;
                  c_idex_bubble = 1'b1;
               end
            end
            STACK: begin
               if (scnt_q != '0) begin
                  c_pc_stall     = 1'b1;
                  c_ifid_stall   = 1'b1;
                  c_idex_stall   = 1'b1;
                  c_exmem_bubble = 1'b1;
                  scnt_d         = scnt_q - SCNT_W'(1);
               end else begin
                  // Release cycle: the op moves on to MEM. Call and ret also redirect the PC.
                  state_d       = RUN;
                  c_redirect    = redir_op;
                  c_ifid_flush  = redir_op;
                  c_idex_bubble = redir_op;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // While reset is held, every control output is forced low.
   assign pc_stall     = rst_n & c_pc_stall;
   assign ifid_stall   = rst_n & c_ifid_stall;
   assign ifid_flush   = rst_n & c_ifid_flush;
   assign idex_stall   = rst_n & c_idex_stall;
   assign idex_bubble  = rst_n & c_idex_bubble;
   assign exmem_stall  = rst_n & c_exmem_stall;
   assign exmem_bubble = rst_n & c_exmem_bubble;
   assign redirect     = rst_n & c_redirect;
   assign busy_state   = (state_q == STACK);
   assign stall_count  = stall_cnt_q;
   assign flush_count  = flush_cnt_q;

   // Saturating perf counters. A clear takes priority over an increment.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (clear_counts) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (pc_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (redirect && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   // State, stack counter and perf counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         scnt_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         scnt_q      <= scnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// u0 uses STACK_LAT=3 and CNT_W=4. u1 uses STACK_LAT=1. Both share the same inputs.
module tb_pipe_hazard_ctrl;
   logic       clk, rst_n;
   logic [4:0] id_rs, id_rt, ex_dest_reg;
   logic       id_rs_used, id_rt_used, ex_mem_read, ex_branch_taken;
   logic       ex_call, ex_ret, ex_pop, mem_busy, clear_counts;

   logic       a_pc, a_ifs, a_iff, a_ids, a_idb, a_exs, a_exb, a_red, a_busy;
   logic [3:0] a_sc, a_fc;
   logic       b_pc, b_ifs, b_iff, b_ids, b_idb, b_exs, b_exb, b_red, b_busy;
   logic [15:0] b_sc, b_fc;

   int tests = 0;
   int fails = 0;

   // Control vector, MSB first: pc_stall ifid_stall ifid_flush idex_stall idex_bubble exmem_stall exmem_bubble redirect
   localparam logic [7:0] C_NONE = 8'h00, C_HZ = 8'hC8, C_BR = 8'h29, C_STK = 8'hD2, C_FRZ = 8'hD4;

   logic [7:0] a_ctl, b_ctl;
   assign a_ctl = {a_pc, a_ifs, a_iff, a_ids, a_idb, a_exs, a_exb, a_red};
   assign b_ctl = {b_pc, b_ifs, b_iff, b_ids, b_idb, b_exs, b_exb, b_red};

   pipe_hazard_ctrl #(.REG_W(5), .STACK_LAT(3), .CNT_W(4)) u0 (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_mem_read(ex_mem_read),
      .ex_dest_reg(ex_dest_reg), .ex_branch_taken(ex_branch_taken), .ex_call(ex_call),
      .ex_ret(ex_ret), .ex_pop(ex_pop), .mem_busy(mem_busy), .clear_counts(clear_counts),
      .pc_stall(a_pc), .ifid_stall(a_ifs), .ifid_flush(a_iff), .idex_stall(a_ids),
      .idex_bubble(a_idb), .exmem_stall(a_exs), .exmem_bubble(a_exb), .redirect(a_red),
      .busy_state(a_busy), .stall_count(a_sc), .flush_count(a_fc));

   pipe_hazard_ctrl #(.REG_W(5), .STACK_LAT(1), .CNT_W(16)) u1 (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_mem_read(ex_mem_read),
      .ex_dest_reg(ex_dest_reg), .ex_branch_taken(ex_branch_taken), .ex_call(ex_call),
      .ex_ret(ex_ret), .ex_pop(ex_pop), .mem_busy(mem_busy), .clear_counts(clear_counts),
      .pc_stall(b_pc), .ifid_stall(b_ifs), .ifid_flush(b_iff), .idex_stall(b_ids),
      .idex_bubble(b_idb), .exmem_stall(b_exs), .exmem_bubble(b_exb), .redirect(b_red),
      .busy_state(b_busy), .stall_count(b_sc), .flush_count(b_fc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_rs = '0; id_rt = '0; id_rs_used = 0; id_rt_used = 0;
      ex_mem_read = 0; ex_dest_reg = '0; ex_branch_taken = 0;
      ex_call = 0; ex_ret = 0; ex_pop = 0; mem_busy = 0; clear_counts = 0;
   endtask

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clk); #1;
   endtask

   initial begin
      // Reset held, with arbitrary inputs applied.
      rst_n = 0; idle();
      #12;
      id_rs = 5'($urandom); id_rt = 5'($urandom); ex_dest_reg = id_rs;
      id_rs_used = 1; ex_mem_read = 1; ex_call = 1; mem_busy = 1; ex_branch_taken = 1;
      #1;
      chk("rst_ctl_u0", 32'(a_ctl), 32'(C_NONE));
      chk("rst_ctl_u1", 32'(b_ctl), 32'(C_NONE));
      chk("rst_busy", 32'(a_busy), 0);
      chk("rst_cnt", 32'({a_sc, a_fc}), 0);
      idle();
      cyc(); rst_n = 1; #1;
      chk("run_after_rst", 32'(a_busy), 0);
      chk("idle_ctl", 32'(a_ctl), 32'(C_NONE));

      // Load-use on rs.
      ex_mem_read = 1; ex_dest_reg = 7; id_rs = 7; id_rs_used = 1; #1;
      chk("hz_rs_u0", 32'(a_ctl), 32'(C_HZ));
      chk("hz_rs_u1", 32'(b_ctl), 32'(C_HZ));
      cyc(); idle();
      chk("hz_stall_cnt", 32'(a_sc), 1);
      // A destination of register 0 never hazards.
      ex_mem_read = 1; ex_dest_reg = 0; id_rs = 0; id_rs_used = 1; #1;
      chk("hz_r0", 32'(a_ctl), 32'(C_NONE));
      cyc(); idle();
      chk("hz_r0_cnt", 32'(a_sc), 1);
      // Load-use on rt. A matching register that is not read does not hazard.
      ex_mem_read = 1; ex_dest_reg = 9; id_rt = 9; id_rt_used = 1; id_rs = 3; id_rs_used = 1; #1;
      chk("hz_rt", 32'(a_ctl), 32'(C_HZ));
      id_rt_used = 0; #1;
      chk("hz_rt_unused", 32'(a_ctl), 32'(C_NONE));
      id_rt_used = 1; cyc(); idle();
      chk("hz_rt_cnt", 32'(a_sc), 2);
      // Without a memory read there is no hazard.
      ex_dest_reg = 9; id_rt = 9; id_rt_used = 1; #1;
      chk("hz_nomemrd", 32'(a_ctl), 32'(C_NONE));
      idle();

      // Clear the counters, then a branch with a coincident hazard.
      clear_counts = 1; cyc(); idle();
      chk("clr_cnt", 32'({a_sc, a_fc}), 0);
      ex_branch_taken = 1; ex_mem_read = 1; ex_dest_reg = 4; id_rs = 4; id_rs_used = 1; #1;
      chk("br_hz", 32'(a_ctl), 32'(C_BR));
      cyc(); idle();
      chk("br_flush_cnt", 32'(a_fc), 1);
      chk("br_stall_cnt", 32'(a_sc), 0);

      // Call held: two stall cycles, then a redirect.
      ex_call = 1; #1;
      chk("call_c1", 32'(a_ctl), 32'(C_STK));
      chk("call_c1_busy", 32'(a_busy), 0);
      chk("call_lat1", 32'(b_ctl), 32'(C_BR));
      chk("call_lat1_busy", 32'(b_busy), 0);
      cyc();
      chk("call_c2", 32'(a_ctl), 32'(C_STK));
      chk("call_c2_busy", 32'(a_busy), 1);
      cyc();
      chk("call_rel", 32'(a_ctl), 32'(C_BR));
      chk("call_rel_busy", 32'(a_busy), 1);
      cyc(); idle(); #1;
      chk("call_done_busy", 32'(a_busy), 0);
      chk("call_cnts", 32'({a_sc, a_fc}), 32'({4'd2, 4'd2}));

      // Pop: two stall cycles and no redirect.
      ex_pop = 1; #1;
      chk("pop_c1", 32'(a_ctl), 32'(C_STK));
      chk("pop_lat1", 32'(b_ctl), 32'(C_NONE));
      cyc();
      chk("pop_c2", 32'(a_ctl), 32'(C_STK));
      cyc();
      chk("pop_rel", 32'(a_ctl), 32'(C_NONE));
      chk("pop_rel_busy", 32'(a_busy), 1);
      cyc(); idle(); #1;
      chk("pop_done_busy", 32'(a_busy), 0);
      chk("pop_cnts", 32'({a_sc, a_fc}), 32'({4'd4, 4'd2}));

      // Ret with a 3-cycle mem_busy freeze in the middle of STACK.
      ex_ret = 1; #1;
      chk("ret_c1", 32'(a_ctl), 32'(C_STK));
      cyc();
      mem_busy = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("ret_frz", 32'(a_ctl), 32'(C_FRZ));
         chk("ret_frz_busy", 32'(a_busy), 1);
         cyc();
      end
      mem_busy = 0; #1;
      chk("ret_c2", 32'(a_ctl), 32'(C_STK));
      cyc();
      chk("ret_rel", 32'(a_ctl), 32'(C_BR));
      cyc(); idle(); #1;
      chk("ret_done_busy", 32'(a_busy), 0);
      chk("ret_cnts", 32'({a_sc, a_fc}), 32'({4'd9, 4'd3}));

      // Stall counter saturation at 15.
      ex_mem_read = 1; ex_dest_reg = 12; id_rs = 12; id_rs_used = 1;
      for (int i = 0; i < 20; i++) cyc();
      chk("sat_stall", 32'(a_sc), 15);
      chk("sat_ctl", 32'(a_ctl), 32'(C_HZ));
      // A clear during a stall wins over the increment.
      clear_counts = 1; cyc(); clear_counts = 0;
      chk("clr_vs_stall", 32'({a_sc, a_fc}), 0);
      idle();

      // Reset asserted in the middle of STACK.
      ex_call = 1; cyc();
      chk("mid_stk_busy", 32'(a_busy), 1);
      #2 rst_n = 0; #1;
      chk("rst_stk_busy", 32'(a_busy), 0);
      chk("rst_stk_ctl", 32'(a_ctl), 32'(C_NONE));
      chk("rst_stk_ctl_u1", 32'(b_ctl), 32'(C_NONE));
      chk("rst_stk_cnt", 32'(a_sc), 0);
      idle(); cyc(); rst_n = 1; #1;
      chk("post_rst_ctl", 32'(a_ctl), 32'(C_NONE));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
